// File: rtl/float_div_stream_ctrl.sv
// ============================================================================
//  Module      : float_div_stream_ctrl
//  Description : Stream front/back-end for a combinational FP32 divider.
//                It holds operand pairs in a FIFO and registers the divider
//                results with valid/ready. It also counts error, overflow and
//                underflow flags in saturating counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module float_div_stream_ctrl #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       clr_cnt,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_a,
    input  logic [31:0]                in_b,
    output logic [31:0]                div_a,
    output logic [31:0]                div_b,
    input  logic [31:0]                div_result,
    input  logic                       div_error,
    input  logic                       div_overflow,
    input  logic                       div_underflow,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_result,
    output logic                       out_error,
    output logic                       out_overflow,
    output logic                       out_underflow,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [CNT_W-1:0]           err_cnt,
    output logic [CNT_W-1:0]           ovf_cnt,
    output logic [CNT_W-1:0]           unf_cnt
);

    localparam int                  c_AW        = $clog2(DEPTH);
    localparam logic [c_AW:0]       c_FULL_LVL  = (c_AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0]    c_CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    logic [31:0]        r_mem_a [DEPTH];
    logic [31:0]        r_mem_b [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_AW:0]      r_level;
    state_t             r_state;
    logic [31:0]        r_result;
    logic               r_error;
    logic               r_overflow;
    logic               r_underflow;
    logic [CNT_W-1:0]   r_err_cnt;
    logic [CNT_W-1:0]   r_ovf_cnt;
    logic [CNT_W-1:0]   r_unf_cnt;

    logic               w_empty;
    logic               w_push;
    logic               w_load;

    // in_ready comes only from the registered level, so a pop frees a slot
    // only on the following cycle.
    assign in_ready = (r_level != c_FULL_LVL);
    assign w_empty  = (r_level == '0);
    assign w_push   = in_valid && in_ready && !flush;
    assign w_load   = !w_empty && ((r_state == ST_EMPTY) || out_ready) && !flush;

    assign div_a = w_empty ? 32'h0 : r_mem_a[r_rd_ptr];
    assign div_b = w_empty ? 32'h0 : r_mem_b[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= in_a;
            r_mem_b[r_wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_load})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Output stage: data registers keep their last value when draining to EMPTY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_result    <= '0;
            r_error     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_state <= ST_EMPTY;
        end else if (w_load) begin
            r_state     <= ST_FULL;
            r_result    <= div_result;
            r_error     <= div_error;
            r_overflow  <= div_overflow;
            r_underflow <= div_underflow;
        end else if ((r_state == ST_FULL) && out_ready) begin
            r_state <= ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
            r_ovf_cnt <= '0;
            r_unf_cnt <= '0;
        end else if (clr_cnt) begin
            r_err_cnt <= '0;
            r_ovf_cnt <= '0;
            r_unf_cnt <= '0;
        end else if (w_load) begin
            if (div_error && (r_err_cnt != c_CNT_MAX)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
            if (div_overflow && (r_ovf_cnt != c_CNT_MAX)) begin
                r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
            end
            if (div_underflow && (r_unf_cnt != c_CNT_MAX)) begin
                r_unf_cnt <= r_unf_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid     = (r_state == ST_FULL);
    assign out_result    = r_result;
    assign out_error     = r_error;
    assign out_overflow  = r_overflow;
    assign out_underflow = r_underflow;
    assign fifo_level    = r_level;
    assign err_cnt       = r_err_cnt;
    assign ovf_cnt       = r_ovf_cnt;
    assign unf_cnt       = r_unf_cnt;

endmodule

`default_nettype wire

// File: tb/tb_float_div_stream_ctrl.sv
// ============================================================================
//  Module      : tb_float_div_stream_ctrl
//  Description : Directed self-checking bench for float_div_stream_ctrl. The
//                combinational divider is replaced by a lookup model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_float_div_stream_ctrl;

    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     flush;
    logic                     clr_cnt;
    logic                     in_valid;
    logic                     in_ready;
    logic [31:0]              in_a;
    logic [31:0]              in_b;
    logic [31:0]              div_a;
    logic [31:0]              div_b;
    logic [31:0]              div_result;
    logic                     div_error;
    logic                     div_overflow;
    logic                     div_underflow;
    logic                     out_valid;
    logic                     out_ready;
    logic [31:0]              out_result;
    logic                     out_error;
    logic                     out_overflow;
    logic                     out_underflow;
    logic [$clog2(DEPTH):0]   fifo_level;
    logic [CNT_W-1:0]         err_cnt;
    logic [CNT_W-1:0]         ovf_cnt;
    logic [CNT_W-1:0]         unf_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    float_div_stream_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .clr_cnt       (clr_cnt),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .div_a         (div_a),
        .div_b         (div_b),
        .div_result    (div_result),
        .div_error     (div_error),
        .div_overflow  (div_overflow),
        .div_underflow (div_underflow),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_error     (out_error),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .fifo_level    (fifo_level),
        .err_cnt       (err_cnt),
        .ovf_cnt       (ovf_cnt),
        .unf_cnt       (unf_cnt)
    );

    // Divider stand-in: known quotients for the operand pairs used below;
    // any divide by 1.0 returns the dividend.
    always_comb begin
        div_result    = 32'h0;
        div_error     = 1'b0;
        div_overflow  = 1'b0;
        div_underflow = 1'b0;
        case ({div_a, div_b})
            {32'h40C00000, 32'h40000000}: div_result = 32'h40400000;
            {32'h3F800000, 32'h40000000}: div_result = 32'h3F000000;
            {32'h41200000, 32'h40A00000}: div_result = 32'h40000000;
            {32'h00000000, 32'h00000000}: begin
                div_result = 32'h7FC00000;
                div_error  = 1'b1;
            end
            {32'h7F000000, 32'h3E800000}: begin
                div_result   = 32'h7F800000;
                div_overflow = 1'b1;
            end
            {32'h00800000, 32'h7F000000}: begin
                div_result    = 32'h00000000;
                div_underflow = 1'b1;
            end
            default: if (div_b == 32'h3F800000) div_result = div_a;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] seq_vals [6];

    initial begin
        seq_vals[0] = 32'h3F800000;
        seq_vals[1] = 32'h40000000;
        seq_vals[2] = 32'h40400000;
        seq_vals[3] = 32'h40800000;
        seq_vals[4] = 32'h40A00000;
        seq_vals[5] = 32'h40C00000;

        rst_n     = 1'b0;
        flush     = 1'b0;
        clr_cnt   = 1'b0;
        in_valid  = 1'b0;
        in_a      = 32'h0;
        in_b      = 32'h0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_result", out_result, 32'h0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_div_a", div_a, 32'h0);

        // Single op 6/2, latency of one edge after acceptance
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 32'h40C00000; in_b = 32'h40000000;
        tick();
        in_valid = 1'b0;
        check("single_level", 32'(fifo_level), 32'd1);
        check("single_valid_early", 32'(out_valid), 32'd0);
        check("single_div_a", div_a, 32'h40C00000);
        tick();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_result", out_result, 32'h40400000);
        check("single_flags", {29'd0, out_error, out_overflow, out_underflow}, 32'd0);
        check("single_err_cnt", 32'(err_cnt), 32'd0);
        check("single_level_drain", 32'(fifo_level), 32'd0);
        tick();
        check("single_drain", 32'(out_valid), 32'd0);
        check("single_hold", out_result, 32'h40400000);

        // Backpressure: first result held stable while out_ready is low
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000;
        tick();
        check("bp_level1", 32'(fifo_level), 32'd1);
        in_a = 32'h41200000; in_b = 32'h40A00000;
        tick();
        in_valid = 1'b0;
        check("bp_level_swap", 32'(fifo_level), 32'd1);
        check("bp_result", out_result, 32'h3F000000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_stable", out_result, 32'h3F000000);
            check("bp_stable_valid", 32'(out_valid), 32'd1);
        end
        check("bp_level_hold", 32'(fifo_level), 32'd1);
        out_ready = 1'b1;
        tick();
        check("bp_next", out_result, 32'h40000000);
        check("bp_level0", 32'(fifo_level), 32'd0);
        tick();
        check("bp_drain", 32'(out_valid), 32'd0);

        // Full FIFO: 4 in FIFO + 1 in output stage, 6th held off
        out_ready = 1'b0;
        in_valid = 1'b1; in_b = 32'h3F800000;
        for (int i = 0; i < 5; i++) begin
            in_a = seq_vals[i];
            tick();
        end
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_level", 32'(fifo_level), 32'd4);
        check("full_head", out_result, 32'h3F800000);
        in_a = seq_vals[5];
        tick();
        check("full_ignored", 32'(fifo_level), 32'd4);
        out_ready = 1'b1;
        tick();
        check("full_out1", out_result, seq_vals[1]);
        check("full_pop_level", 32'(fifo_level), 32'd3);
        check("full_slot_free", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("full_out2", out_result, seq_vals[2]);
        check("full_pushpop_level", 32'(fifo_level), 32'd3);
        for (int i = 3; i < 6; i++) begin
            tick();
            check("full_order", out_result, seq_vals[i]);
        end
        check("full_level_end", 32'(fifo_level), 32'd0);
        tick();
        check("full_drain", 32'(out_valid), 32'd0);

        // Flags and counters
        in_valid = 1'b1; in_a = 32'h00000000; in_b = 32'h00000000;
        tick();
        in_a = 32'h7F000000; in_b = 32'h3E800000;
        tick();
        in_valid = 1'b0;
        check("flag_err", 32'(out_error), 32'd1);
        check("flag_err_result", out_result, 32'h7FC00000);
        check("flag_err_cnt", 32'(err_cnt), 32'd1);
        tick();
        check("flag_ovf", {30'd0, out_error, out_overflow}, 32'd1);
        check("flag_ovf_result", out_result, 32'h7F800000);
        check("flag_ovf_cnt", 32'(ovf_cnt), 32'd1);
        in_valid = 1'b1; in_a = 32'h00800000; in_b = 32'h7F000000;
        tick();
        in_valid = 1'b0;
        tick();
        check("flag_unf", 32'(out_underflow), 32'd1);
        check("flag_unf_cnt", 32'(unf_cnt), 32'd1);
        check("flag_err_cnt_keep", 32'(err_cnt), 32'd1);
        tick();

        // Saturation at 2^CNT_W-1 = 3, then clear beats increment
        in_valid = 1'b1; in_a = 32'h0; in_b = 32'h0;
        tick();
        tick();
        check("sat_err2", 32'(err_cnt), 32'd2);
        tick();
        check("sat_err3", 32'(err_cnt), 32'd3);
        tick();
        in_valid = 1'b0;
        tick();
        check("sat_hold", 32'(err_cnt), 32'd3);
        check("sat_level", 32'(fifo_level), 32'd0);
        tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("clr_err", 32'(err_cnt), 32'd0);
        check("clr_ovf", 32'(ovf_cnt), 32'd0);
        check("clr_unf", 32'(unf_cnt), 32'd0);
        check("clr_loaded", 32'(out_error), 32'd1);
        tick();

        // Flush with 3 queued plus a valid output
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 32'h0; in_b = 32'h0;
        repeat (4) tick();
        check("flush_pre_level", 32'(fifo_level), 32'd3);
        check("flush_pre_valid", 32'(out_valid), 32'd1);
        check("flush_pre_err", 32'(err_cnt), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_level", 32'(fifo_level), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_err_kept", 32'(err_cnt), 32'd1);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("flush_discard", 32'(fifo_level), 32'd0);

        // Asynchronous reset mid-stream
        in_valid = 1'b1; in_a = 32'h40C00000; in_b = 32'h40000000;
        repeat (2) tick();
        in_valid = 1'b0;
        check("arst_pre_valid", 32'(out_valid), 32'd1);
        check("arst_pre_level", 32'(fifo_level), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_level", 32'(fifo_level), 32'd0);
        check("arst_result", out_result, 32'h0);
        check("arst_err_cnt", 32'(err_cnt), 32'd0);
        check("arst_div_a", div_a, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_idle", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
